// File: rtl/bchecc_enc_par.sv
// Multi-bit-per-cycle BCH parity encoder: DW unrolled LFSR division steps per
// accepted message word, then the ECC_W-bit remainder is streamed out DW bits at a time.
module bchecc_enc_par #(
    parameter int unsigned ECC_W = 195,
    parameter int unsigned DW    = 8,
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [LEN_W-1:0] msg_len_i,
    input  logic [ECC_W-1:0] gen_poly_i,
    input  logic [DW-1:0]    data_i,
    input  logic             data_vld_i,
    output logic             data_rdy_o,
    output logic [DW-1:0]    ecc_o,
    output logic             ecc_vld_o,
    input  logic             ecc_rdy_i,
    output logic             ecc_last_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned NW  = (ECC_W + DW - 1) / DW;
    localparam int unsigned PCW = $clog2(NW + 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StDone} state_e;

    state_e           state;
    logic [ECC_W-1:0] gen;
    logic [ECC_W-1:0] rem;
    logic [ECC_W-1:0] rem_step;
    logic [LEN_W-1:0] word_cnt;
    logic [PCW-1:0]   par_cnt;
    logic             data_xfer;
    logic             ecc_xfer;

    assign data_xfer = data_vld_i & data_rdy_o;
    assign ecc_xfer  = ecc_vld_o & ecc_rdy_i;
    assign ecc_o     = ecc_vld_o ? rem[DW-1:0] : '0;

    // DW chained single-bit division steps, data_i[0] first.
    always_comb begin
        rem_step = rem;
        for (int unsigned i = 0; i < DW; i++) begin
            rem_step = ({ECC_W{data_i[i] ^ rem_step[0]}} & gen) ^ (rem_step >> 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            gen        <= '0;
            rem        <= '0;
            word_cnt   <= '0;
            par_cnt    <= '0;
            data_rdy_o <= 1'b0;
            ecc_vld_o  <= 1'b0;
            ecc_last_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start_i) begin
                        gen      <= gen_poly_i;
                        rem      <= '0;
                        word_cnt <= msg_len_i;
                        par_cnt  <= '0;
                        busy_o   <= 1'b1;
                        if (msg_len_i != '0) begin
                            state      <= StData;
                            data_rdy_o <= 1'b1;
                        end else begin
                            state      <= StParity;
                            ecc_vld_o  <= 1'b1;
                            ecc_last_o <= (NW == 1);
                        end
                    end
                end
                StData: begin
                    if (data_xfer) begin
                        rem      <= rem_step;
                        word_cnt <= word_cnt - LEN_W'(1);
                        if (word_cnt == LEN_W'(1)) begin
                            state      <= StParity;
                            data_rdy_o <= 1'b0;
                            ecc_vld_o  <= 1'b1;
                            ecc_last_o <= (NW == 1);
                        end
                    end
                end
                StParity: begin
                    if (ecc_xfer) begin
                        // Zero fill leaves rem cleared once all NW words have gone out.
                        rem        <= rem >> DW;
                        par_cnt    <= par_cnt + PCW'(1);
                        ecc_last_o <= (par_cnt == PCW'(NW - 2));
                        if (ecc_last_o) begin
                            state      <= StDone;
                            ecc_vld_o  <= 1'b0;
                            ecc_last_o <= 1'b0;
                            done_o     <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    state  <= StIdle;
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/bchecc_enc_par.md
Name: bchecc_enc_par

Overview:
Parametrised, multi-bit-per-cycle BCH parity encoder. It is the sequential successor to the single-bit modgenpoly remainder step. It absorbs a message of msg_len_i words (DW bits each) through a valid/ready handshake and applies DW unrolled LFSR division steps per cycle. It then streams the ECC_W-bit remainder out in DW-bit words. It sits between the NFC page buffer and the flash write path.

Parameters:
ECC_W, 195, remainder/parity width in bits (generator polynomial width excluding the implicit top term)
DW, 8, message and parity bits per cycle
LEN_W, 16, width of message length counter

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start_i  input  1  one-cycle pulse that begins a codeword; honoured only in IDLE
msg_len_i  input  LEN_W  message length in DW-bit words; sampled on accepted start
gen_poly_i  input  ECC_W  generator polynomial; sampled on accepted start
data_i  input  DW  message word; bit 0 is processed first
data_vld_i  input  1  data_i valid
data_rdy_o  output  1  encoder accepts data (transfer when vld and rdy)
ecc_o  output  DW  parity word
ecc_vld_o  output  1  ecc_o valid
ecc_rdy_i  input  1  downstream accepts parity (transfer when vld and rdy)
ecc_last_o  output  1  marks the final parity word
busy_o  output  1  high in any state other than IDLE
done_o  output  1  one-cycle pulse after the last parity word transfers

Behaviour:
- Reset values: all outputs 0; state IDLE; remainder r = 0; counters 0.
- Single-bit step, identical to the existing block: c = d ^ r[0]; r_next = ({ECC_W{c}} & g) ^ {1'b0, r[ECC_W-1:1]}.
  - Per accepted word, apply the step DW times combinationally, in order data_i[0] .. data_i[DW-1].
  - The result is registered in the same cycle as the transfer.
- NW = ceil(ECC_W/DW) parity words; NW = 25 at defaults.
- IDLE:
  - On start_i: latch msg_len_i and gen_poly_i, clear r.
  - If msg_len_i != 0, go to DATA; if msg_len_i == 0, go to PARITY.
  - start_i outside IDLE is ignored.
- DATA:
  - data_rdy_o = 1.
  - Each transfer updates r and decrements the word counter.
  - On the transfer of the last word, go to PARITY next cycle; data_rdy_o drops in that cycle.
  - No bubble is required between words. data_vld_i low simply stalls.
- PARITY:
  - ecc_vld_o = 1; ecc_o = r[DW-1:0].
  - On each transfer, r shifts right by DW with zero fill; the final word is zero-padded above bit ECC_W mod DW.
  - ecc_last_o = 1 on word NW-1 only.
  - ecc_rdy_i low holds ecc_o, ecc_vld_o and ecc_last_o stable.
  - After the last transfer, go to DONE.
- DONE: done_o = 1 for exactly one cycle, then IDLE. busy_o falls in the IDLE cycle.
- Latency:
  - First data_rdy_o is the cycle after start.
  - First ecc_vld_o is the cycle after the last data transfer.
  - Minimum total is 1 + msg_len + NW + 1 cycles.
- rst in any state: return to IDLE immediately, discard r and counters, drop all outputs next cycle.
- Width rule: ECC_W >= DW >= 1; DW need not divide ECC_W.

Test Plan:
- Reset mid-DATA (after 3 of 10 words) -> next cycle busy_o = 0, data_rdy_o = 0. A new start with 1 word of 8'h00 gives 25 words of 8'h00.
- gen_poly = 195'h1, msg_len = 1, data = 8'h01 -> parity word0 = 8'h01, words 1..24 = 8'h00, ecc_last_o on word 24, done_o one cycle later.
- gen_poly = 195'h2, msg_len = 1, data = 8'h01 -> r = 195'h1 (alternating 2/1 per bit, ends at 1); word0 = 8'h01, rest 0.
- msg_len = 0 -> PARITY entered directly; 25 zero words; data_rdy_o never asserted.
- Random gen_poly and 512-word message with random data_vld_i gaps and ecc_rdy_i backpressure:
  - Parity matches a bit-serial model of the single-bit step equation.
  - ecc_o is stable while stalled; exactly 25 parity transfers.
- start_i pulsed during DATA and PARITY -> ignored; msg_len and gen_poly unchanged; output matches the uninterrupted run.
